// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: op codes, FSM state encoding
// and the bit positions of the packed flag vector.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam int FLAG_C    = 0;
   localparam int FLAG_Z    = 1;
   localparam int FLAG_N    = 2;
   localparam int FLAG_V    = 3;
   localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// product is combinational and already includes the step being taken this cycle.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   data_1,
   input  logic [WIDTH-1:0]   data_2,
   output logic               finish,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] addend;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   assign addend  = mplier[0] ? mcand : '0;
   assign product = acc + addend;
   assign finish  = step && (count == LAST_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, data_1};
         mplier <= data_2;
         acc    <= '0;
         count  <= '0;
      end else if (step) begin
         acc    <= product;
         mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
         mplier <= {1'b0, mplier[WIDTH-1:1]};
         count  <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with add/sub/logic/shift in one cycle and an optional
// iterative multiply, fronted by a start/busy/done handshake.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit ENABLE_MUL = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   // state    | meaning
   // ST_IDLE  | waiting for start; single-cycle ops complete from here
   // ST_MUL   | shift-add multiply in progress, start ignored

   localparam int MSB = WIDTH - 1;

   state_t state, state_next;

   logic                 accept;
   logic                 mul_go;
   logic                 single_go;
   logic                 mul_load;
   logic                 mul_step;
   logic                 mul_finish;
   logic [2*WIDTH-1:0]   mul_product;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic [NUM_FLAGS-1:0] alu_flags;
   logic [NUM_FLAGS-1:0] mul_flags;
   logic [NUM_FLAGS-1:0] flags;

   function automatic logic [NUM_FLAGS-1:0] pack_flags(
      input logic [WIDTH-1:0] res,
      input logic             c,
      input logic             v
   );
      logic [NUM_FLAGS-1:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_Z] = (res == '0);
      f[FLAG_N] = res[MSB];
      f[FLAG_V] = v;
      return f;
   endfunction

   assign accept    = (state == ST_IDLE) && start;
   assign mul_go    = accept && (op == OP_MUL) && ENABLE_MUL;
   assign single_go = accept && !mul_go;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (mul_go)     state_next = ST_MUL;
         ST_MUL:  if (mul_finish) state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ST_MUL);
      mul_load = mul_go;
      mul_step = (state == ST_MUL);
   end

   // With ENABLE_MUL=0 load never fires, so the multiplier is constant-folded away.
   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (mul_load),
      .step    (mul_step),
      .data_1  (data_1),
      .data_2  (data_2),
      .finish  (mul_finish),
      .product (mul_product)
   );

   assign sum  = {1'b0, data_1} + {1'b0, data_2};
   assign diff = {1'b0, data_1} - {1'b0, data_2};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (data_1[MSB] == data_2[MSB]) && (sum[MSB] != data_1[MSB]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (data_1[MSB] != data_2[MSB]) && (diff[MSB] != data_1[MSB]);
         end
         OP_AND: alu_res = data_1 & data_2;
         OP_OR:  alu_res = data_1 | data_2;
         OP_XOR: alu_res = data_1 ^ data_2;
         OP_SHL: begin
            alu_res = {data_1[WIDTH-2:0], 1'b0};
            alu_c   = data_1[MSB];
         end
         OP_SHR: begin
            alu_res = {1'b0, data_1[WIDTH-1:1]};
            alu_c   = data_1[0];
         end
         default: begin
            // MUL reaching the single-cycle path means the multiplier is disabled.
            alu_res = '0;
         end
      endcase
   end

   assign alu_flags = pack_flags(alu_res, alu_c, alu_v);
   assign mul_flags = pack_flags(mul_product[WIDTH-1:0],
                                 |mul_product[2*WIDTH-1:WIDTH],
                                 |mul_product[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= '0;
         flags    <= '0;
         done     <= 1'b0;
      end else begin
         done <= single_go || mul_finish;
         if (single_go) begin
            data_out <= alu_res;
            flags    <= alu_flags;
         end else if (mul_finish) begin
            data_out <= mul_product[WIDTH-1:0];
            flags    <= mul_flags;
         end
      end
   end

   assign carry    = flags[FLAG_C];
   assign zero     = flags[FLAG_Z];
   assign negative = flags[FLAG_N];
   assign overflow = flags[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one instance with the multiplier, one without.
module tb_alu_seq;
   import alu_pkg::*;

   logic       clk;
   logic       reset;
   logic       start;
   logic       start0;
   logic [2:0] op;
   logic [7:0] data_1;
   logic [7:0] data_2;

   logic       busy, done, carry, zero, negative, overflow;
   logic [7:0] data_out;
   logic       busy0, done0, carry0, zero0, negative0, overflow0;
   logic [7:0] data_out0;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(8), .ENABLE_MUL(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .data_1(data_1), .data_2(data_2),
      .busy(busy), .done(done), .data_out(data_out),
      .carry(carry), .zero(zero), .negative(negative), .overflow(overflow)
   );

   alu_seq #(.WIDTH(8), .ENABLE_MUL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .op(op),
      .data_1(data_1), .data_2(data_2),
      .busy(busy0), .done(done0), .data_out(data_out0),
      .carry(carry0), .zero(zero0), .negative(negative0), .overflow(overflow0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {busy, done, data_out, carry, zero, negative, overflow}
   function automatic logic [13:0] obs();
      return {busy, done, data_out, carry, zero, negative, overflow};
   endfunction

   function automatic logic [13:0] obs0();
      return {busy0, done0, data_out0, carry0, zero0, negative0, overflow0};
   endfunction

   function automatic logic [13:0] exp_v(input logic b, input logic d, input logic [7:0] r,
                                          input logic c, input logic z, input logic n,
                                          input logic v);
      return {b, d, r, c, z, n, v};
   endfunction

   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      data_1 = a;
      data_2 = b;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Starts a MUL; returns at the negedge where done is seen (or after the budget).
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                          output int busy_cyc, output bit held, output bit got);
      logic [7:0] prev;
      prev     = data_out;
      busy_cyc = 0;
      held     = 1'b1;
      got      = 1'b0;
      issue(OP_MUL, a, b);
      data_1 = 8'hAA;
      data_2 = 8'h55;
      for (int i = 0; i < 20 && !got; i++) begin
         if (done) got = 1'b1;
         else begin
            if (busy) busy_cyc++;
            if (data_out !== prev) held = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start0 = 1'b0;
      op = OP_ADD; data_1 = 8'd0; data_2 = 8'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs() !== 14'd0) begin
         errors++; $display("FAIL reset_state: got %h expected %h", obs(), 14'd0);
      end
      checks++;
      if (obs0() !== 14'd0) begin
         errors++; $display("FAIL reset_state_nomul: got %h expected %h", obs0(), 14'd0);
      end
      reset = 1'b0;
   endtask

   task automatic test_arith();
      issue(OP_ADD, 8'd200, 8'd100);
      checks++;
      if (obs() !== exp_v(0, 1, 8'd44, 1, 0, 0, 0)) begin
         errors++; $display("FAIL add_carry: got %h expected %h", obs(), exp_v(0, 1, 8'd44, 1, 0, 0, 0));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL add_done_drop: got %b expected 0", done);
      end
      issue(OP_ADD, 8'd100, 8'd50);
      checks++;
      if (obs() !== exp_v(0, 1, 8'd150, 0, 0, 1, 1)) begin
         errors++; $display("FAIL add_overflow: got %h expected %h", obs(), exp_v(0, 1, 8'd150, 0, 0, 1, 1));
      end
      issue(OP_SUB, 8'd5, 8'd5);
      checks++;
      if (obs() !== exp_v(0, 1, 8'd0, 0, 1, 0, 0)) begin
         errors++; $display("FAIL sub_zero: got %h expected %h", obs(), exp_v(0, 1, 8'd0, 0, 1, 0, 0));
      end
      issue(OP_SUB, 8'd3, 8'd5);
      checks++;
      if (obs() !== exp_v(0, 1, 8'd254, 1, 0, 1, 0)) begin
         errors++; $display("FAIL sub_borrow: got %h expected %h", obs(), exp_v(0, 1, 8'd254, 1, 0, 1, 0));
      end
      issue(OP_SUB, 8'h80, 8'h01);
      checks++;
      if (obs() !== exp_v(0, 1, 8'h7F, 0, 0, 0, 1)) begin
         errors++; $display("FAIL sub_overflow: got %h expected %h", obs(), exp_v(0, 1, 8'h7F, 0, 0, 0, 1));
      end
   endtask

   task automatic test_logic_shift();
      issue(OP_SHL, 8'h81, 8'h00);
      checks++;
      if (obs() !== exp_v(0, 1, 8'h02, 1, 0, 0, 0)) begin
         errors++; $display("FAIL shl: got %h expected %h", obs(), exp_v(0, 1, 8'h02, 1, 0, 0, 0));
      end
      issue(OP_SHR, 8'h01, 8'h00);
      checks++;
      if (obs() !== exp_v(0, 1, 8'h00, 1, 1, 0, 0)) begin
         errors++; $display("FAIL shr: got %h expected %h", obs(), exp_v(0, 1, 8'h00, 1, 1, 0, 0));
      end
      issue(OP_AND, 8'hF0, 8'h3C);
      checks++;
      if (obs() !== exp_v(0, 1, 8'h30, 0, 0, 0, 0)) begin
         errors++; $display("FAIL and: got %h expected %h", obs(), exp_v(0, 1, 8'h30, 0, 0, 0, 0));
      end
      issue(OP_OR, 8'h81, 8'h12);
      checks++;
      if (obs() !== exp_v(0, 1, 8'h93, 0, 0, 1, 0)) begin
         errors++; $display("FAIL or: got %h expected %h", obs(), exp_v(0, 1, 8'h93, 0, 0, 1, 0));
      end
      issue(OP_XOR, 8'hFF, 8'h0F);
      checks++;
      if (obs() !== exp_v(0, 1, 8'hF0, 0, 0, 1, 0)) begin
         errors++; $display("FAIL xor: got %h expected %h", obs(), exp_v(0, 1, 8'hF0, 0, 0, 1, 0));
      end
   endtask

   task automatic test_mul();
      int bc; bit held; bit got;
      run_mul(8'd15, 8'd17, bc, held, got);
      checks++;
      if (!got || bc != 8) begin
         errors++; $display("FAIL mul_latency: got busy_cycles=%0d done_seen=%0b expected 8 and 1", bc, got);
      end
      checks++;
      if (obs() !== exp_v(0, 1, 8'd255, 0, 0, 1, 0)) begin
         errors++; $display("FAIL mul_255: got %h expected %h", obs(), exp_v(0, 1, 8'd255, 0, 0, 1, 0));
      end
      checks++;
      if (!held) begin
         errors++; $display("FAIL mul_hold: data_out changed while busy, expected held at f0");
      end
      run_mul(8'd16, 8'd16, bc, held, got);
      checks++;
      if (!got || obs() !== exp_v(0, 1, 8'd0, 1, 1, 0, 1)) begin
         errors++; $display("FAIL mul_256: got %h expected %h", obs(), exp_v(0, 1, 8'd0, 1, 1, 0, 1));
      end
      checks++;
      if (!held) begin
         errors++; $display("FAIL mul_hold2: data_out changed while busy, expected held at ff");
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL mul_done_drop: got %b expected 0", done);
      end
   endtask

   task automatic test_start_while_busy();
      int dones; logic [7:0] res; logic c;
      dones = 0; res = 8'hXX; c = 1'bx;
      issue(OP_MUL, 8'd15, 8'd17);
      @(negedge clk);
      start = 1'b1; op = OP_ADD; data_1 = 8'd1; data_2 = 8'd1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (done) begin
            dones++; res = data_out; c = carry;
         end
         @(negedge clk);
      end
      checks++;
      if (dones != 1 || res !== 8'd255 || c !== 1'b0) begin
         errors++; $display("FAIL busy_ignore: got dones=%0d result=%h carry=%b expected 1, ff, 0", dones, res, c);
      end
   endtask

   task automatic test_back_to_back();
      int bc; bit held; bit got;
      @(negedge clk);
      start = 1'b1; op = OP_ADD; data_1 = 8'd1; data_2 = 8'd2;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || data_out !== 8'd3) begin
         errors++; $display("FAIL b2b_first: got done=%b out=%h expected 1, 03", done, data_out);
      end
      op = OP_SUB; data_1 = 8'd10; data_2 = 8'd3;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || data_out !== 8'd7) begin
         errors++; $display("FAIL b2b_second: got done=%b out=%h expected 1, 07", done, data_out);
      end
      run_mul(8'd3, 8'd5, bc, held, got);
      start = 1'b1; op = OP_ADD; data_1 = 8'd2; data_2 = 8'd2;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (!got || done !== 1'b1 || data_out !== 8'd4 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_after_mul: got done=%b out=%h busy=%b expected 1, 04, 0", done, data_out, busy);
      end
   endtask

   task automatic test_reset_mid_mul();
      int dones;
      dones = 0;
      issue(OP_MUL, 8'd200, 8'd200);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== 14'd0) begin
         errors++; $display("FAIL reset_mid_mul: got %h expected %h", obs(), 14'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL reset_abort: got %0d done/busy cycles expected 0", dones);
      end
   endtask

   task automatic test_no_mul();
      @(negedge clk);
      start0 = 1'b1; op = OP_MUL; data_1 = 8'd3; data_2 = 8'd3;
      @(negedge clk);
      start0 = 1'b0;
      checks++;
      if (obs0() !== exp_v(0, 1, 8'd0, 0, 1, 0, 0)) begin
         errors++; $display("FAIL nomul_mul: got %h expected %h", obs0(), exp_v(0, 1, 8'd0, 0, 1, 0, 0));
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++; $display("FAIL nomul_done_drop: got done=%b busy=%b expected 0, 0", done0, busy0);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic_shift();
      test_mul();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_mul();
      test_no_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
